// File: rtl/mono_sample_frame_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : mono_sample_frame_buffer
//  Description : Ping-pong frame buffer. Collects FRAME_LEN mono samples per
//                bank and streams each completed bank out on an AXI-Stream
//                master, one beat per two cycles, TLAST on the final sample.
//                Samples that arrive while both banks are full are dropped
//                and counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module mono_sample_frame_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_LEN  = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  M_AXIS_ACLK,
    input  logic                  M_AXIS_ARESETN,
    input  logic                  mono_sample_valid,
    input  logic [DATA_WIDTH-1:0] mono_sample,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TLAST,
    output logic                  frame_overflow,
    output logic [15:0]           dropped_count
);

    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2
    } rd_state_t;

    // Sample storage, never reset
    logic [DATA_WIDTH-1:0] r_bank0 [FRAME_LEN];
    logic [DATA_WIDTH-1:0] r_bank1 [FRAME_LEN];

    logic [1:0]            r_rst_sync;
    logic [1:0]            r_full;
    logic                  r_fill_bank;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic                  r_wait;
    logic                  r_overflow;
    logic [15:0]           r_dropped;

    rd_state_t             r_state;
    logic                  r_rd_bank;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic [DATA_WIDTH-1:0] r_tdata;

    logic w_run;
    logic w_wr_en;
    logic w_drop;
    logic w_wr_last;
    logic w_release;
    logic w_other;
    logic w_other_free;

    // Logic stays frozen until the synchronised release reaches the second flop,
    // so the edge that sees reset rise changes nothing.
    assign w_run        = r_rst_sync[1];
    assign w_wr_en      = w_run & mono_sample_valid & ~r_wait;
    assign w_drop       = w_run & mono_sample_valid &  r_wait;
    assign w_wr_last    = w_wr_en & (r_wr_ptr == c_LAST_ADDR);
    assign w_release    = w_run & (r_state == S_SEND) & M_AXIS_TREADY & (r_rd_addr == c_LAST_ADDR);
    assign w_other      = ~r_fill_bank;
    // The other bank is usable if empty or being handed back on this very edge
    assign w_other_free = ~r_full[w_other] | (w_release & (r_rd_bank == w_other));

    // Reset release synchroniser: asynchronous assert, two-flop deassert
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) r_rst_sync <= 2'b00;
        else                 r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    // Sample RAM write port
    always_ff @(posedge M_AXIS_ACLK) begin
        if (w_wr_en) begin
            if (r_fill_bank) r_bank1[r_wr_ptr] <= mono_sample;
            else             r_bank0[r_wr_ptr] <= mono_sample;
        end
    end

    // Writer: fill pointer, bank switching, WAIT on overflow, drop accounting
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_fill_bank <= 1'b0;
            r_wr_ptr    <= '0;
            r_wait      <= 1'b0;
            r_overflow  <= 1'b0;
            r_dropped   <= 16'd0;
        end else begin
            r_overflow <= w_drop;
            if (w_drop && (r_dropped != 16'hFFFF)) r_dropped <= r_dropped + 16'd1;
            if (w_wr_en) begin
                if (w_wr_last) begin
                    r_wr_ptr    <= '0;
                    // fill_bank always points at the next bank; r_wait says whether it is usable yet
                    r_fill_bank <= w_other;
                    r_wait      <= ~w_other_free;
                end else begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
            end else if (r_wait && w_release && (r_rd_bank == r_fill_bank)) begin
                r_wait <= 1'b0;
            end
        end
    end

    // Bank full flags: set by the writer on completion, cleared by the reader on release
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_full <= 2'b00;
        end else begin
            if (w_wr_last) r_full[r_fill_bank] <= 1'b1;
            if (w_release) r_full[r_rd_bank]   <= 1'b0;
        end
    end

    // Reader FSM: IDLE waits for a full bank, READ fetches one word, SEND holds it until accepted
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_state   <= S_IDLE;
            r_rd_bank <= 1'b0;
            r_rd_addr <= '0;
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
            r_tdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_run && r_full[r_rd_bank]) begin
                        r_rd_addr <= '0;
                        r_state   <= S_READ;
                    end
                end
                S_READ: begin
                    r_tdata  <= r_rd_bank ? r_bank1[r_rd_addr] : r_bank0[r_rd_addr];
                    r_tvalid <= 1'b1;
                    r_tlast  <= (r_rd_addr == c_LAST_ADDR);
                    r_state  <= S_SEND;
                end
                S_SEND: begin
                    if (M_AXIS_TREADY) begin
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
                        if (r_rd_addr == c_LAST_ADDR) begin
                            r_rd_bank <= ~r_rd_bank;
                            r_state   <= S_IDLE;
                        end else begin
                            r_rd_addr <= r_rd_addr + 1'b1;
                            r_state   <= S_READ;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign M_AXIS_TVALID  = r_tvalid;
    assign M_AXIS_TDATA   = r_tdata;
    assign M_AXIS_TLAST   = r_tlast;
    assign frame_overflow = r_overflow;
    assign dropped_count  = r_dropped;

endmodule
`default_nettype wire
